// File: rtl/counter_pkg.sv
// Shared constants for the counter family: default width and state encoding.
package counter_pkg;

    // Default counter width; legal range is 2..16.
    localparam int COUNTER_WIDTH = 3;

    // Single-bit state encoding, kept as plain constants for legacy tools.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/down_counter_load_if.sv
// Control/status bundle between a controller and the loadable down counter.
//
// Handshake: there is no valid/ready pair. load and en are single-cycle
// qualifiers sampled on every rising edge (load wins over en); count, tc and
// running are registered status that is valid for the whole cycle after the
// edge that produced it.
interface down_counter_load_if #(
    parameter int WIDTH = 3
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             auto;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             running;

    // Controller side: drives the strobes and start value, observes status.
    modport master (
        output en,
        output load,
        output load_val,
        output auto,
        input  count,
        input  tc,
        input  running
    );

    // Counter side: consumes the strobes and produces status.
    modport slave (
        input  en,
        input  load,
        input  load_val,
        input  auto,
        output count,
        output tc,
        output running
    );
endinterface

// File: rtl/dff_sr.sv
// One-bit D flip-flop with synchronous active-high reset to 0.
module dff_sr (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    // Capture d on every rising edge; reset wins and clears to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_o <= 1'b0;
        end else begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/down_counter_load.sv
// Loadable down counter with one-cycle terminal-count pulse and optional
// auto-reload. Datapath is a gate-level borrow-chain decrementer feeding a
// one-hot AND/OR next-state mux, stored in per-bit dff_sr cells.
module down_counter_load
    import counter_pkg::*;
#(
    parameter int WIDTH = COUNTER_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    down_counter_load_if.slave  bus
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             auto_q, auto_d;
    logic [0:0]       st_q, st_d;
    logic             tc_q, tc_d;

    logic [WIDTH-1:0] lv;
    logic [WIDTH-1:0] cnt_n;
    logic [WIDTH-1:0] dec;
    logic [WIDTH-1:1] borrow;
    logic [WIDTH-1:0] t_load, t_rel, t_dec, t_hold;

    logic hi_zero, is_zero, is_one, lv_nz;
    logic sel_load, step, sel_reload, sel_dec, sel_hold;
    logic go_run, go_idle, end_oneshot;

    assign lv       = bus.load_val;
    assign lv_nz    = |lv;
    assign hi_zero  = ~|cnt_q[WIDTH-1:1];
    assign is_one   = hi_zero & cnt_q[0];

    // Priority is load over enable; enable only advances the count in RUN,
    // so IDLE never decrements and never wraps to all-ones.
    assign sel_load   = bus.load;
    assign step       = ~sel_load & bus.en & (st_q == ST_RUN);
    // count=0 while in RUN only happens in auto-reload mode.
    assign sel_reload = step & is_zero;
    assign sel_dec    = step & ~is_zero;
    assign sel_hold   = ~sel_load & ~step;

    // Terminal count fires on the 1->0 step; a load on that edge suppresses it.
    assign tc_d        = step & is_one;
    assign end_oneshot = tc_d & ~auto_q;

    // A zero load parks the counter in IDLE; one-shot expiry does the same.
    assign go_run  = sel_load & lv_nz;
    assign go_idle = (sel_load & ~lv_nz) | end_oneshot;
    assign st_d    = go_run ? ST_RUN : (go_idle ? ST_IDLE : st_q);

    // Reload value and mode are captured on every load, including zero loads.
    assign reload_d = (lv & {WIDTH{sel_load}}) | (reload_q & {WIDTH{~sel_load}});
    assign auto_d   = sel_load ? bus.auto : auto_q;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            not g_inv (cnt_n[i], cnt_q[i]);

            // Borrow chain: bit i toggles when every lower bit is 0.
            if (i == 0) begin : g_lsb
                not g_dec (dec[i], cnt_q[i]);
            end else begin : g_upper
                if (i == 1) begin : g_first
                    assign borrow[i] = cnt_n[0];
                end else begin : g_chain
                    and g_borrow (borrow[i], borrow[i-1], cnt_n[i-1]);
                end
                xor g_dec (dec[i], cnt_q[i], borrow[i]);
            end

            // One-hot select of load / reload / decrement / hold per bit.
            and g_a0 (t_load[i], sel_load,   lv[i]);
            and g_a1 (t_rel[i],  sel_reload, reload_q[i]);
            and g_a2 (t_dec[i],  sel_dec,    dec[i]);
            and g_a3 (t_hold[i], sel_hold,   cnt_q[i]);
            or  g_o0 (cnt_d[i],  t_load[i], t_rel[i], t_dec[i], t_hold[i]);

            dff_sr u_cnt (.clk(clk), .rst(rst), .d_i(cnt_d[i]),    .q_o(cnt_q[i]));
            dff_sr u_rel (.clk(clk), .rst(rst), .d_i(reload_d[i]), .q_o(reload_q[i]));
        end
    endgenerate

    // All-zero detect reuses the end of the borrow chain.
    and g_zero (is_zero, borrow[WIDTH-1], cnt_n[WIDTH-1]);

    dff_sr u_auto  (.clk(clk), .rst(rst), .d_i(auto_d),  .q_o(auto_q));
    dff_sr u_state (.clk(clk), .rst(rst), .d_i(st_d[0]), .q_o(st_q[0]));
    dff_sr u_tc    (.clk(clk), .rst(rst), .d_i(tc_d),    .q_o(tc_q));

    assign bus.count   = cnt_q;
    assign bus.tc      = tc_q;
    assign bus.running = (st_q == ST_RUN);

endmodule

// File: doc/down_counter_load.md
# down_counter_load

Loadable synchronous down counter with a terminal-count pulse and an optional auto-reload mode. It counts in the opposite direction to the free-running up counter in the sequential library. It serves as the countdown/timer companion: an external controller loads a start value, the block decrements on each enabled clock, and it flags arrival at zero. The datapath is built at gate level from a per-bit next-state network plus a single-bit synchronous-reset flip-flop cell.

## Interface
Parameters:
- WIDTH, 3, counter width in bits (legal range 2..16)

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  count enable; the counter decrements only on edges where en=1
- load  input  1  load strobe; captures load_val and auto on this edge
- load_val  input  WIDTH  start value; also stored as the reload value
- auto  input  1  mode captured at load; 1 = auto-reload, 0 = one-shot
- count  output  WIDTH  current counter value
- tc  output  1  terminal-count pulse, one cycle wide
- running  output  1  high while the counter is in state RUN

## Operation
- Registers: count[WIDTH], reload_reg[WIDTH], auto_reg, state (IDLE/RUN), tc.
- Priority on each rising edge: rst, then load, then en.
- rst=1: count=0, reload_reg=0, auto_reg=0, state=IDLE, tc=0, running=0.
- load=1 with load_val≠0:
  - count=load_val, reload_reg=load_val, auto_reg=auto, state=RUN, tc=0.
  - This applies in any state, so a load during RUN restarts the count.
- load=1 with load_val=0: count=0, state=IDLE, tc=0. Capture of reload_reg and auto_reg still happens.
- In RUN with en=1 and count>1: count=count−1.
- In RUN with en=1 and count=1: count=0 and tc=1 on the next cycle.
  - If auto_reg=0, state becomes IDLE.
  - If auto_reg=1, state stays RUN.
- In RUN with en=1 and count=0 (auto-reload only): count=reload_reg, tc=0.
- In RUN with en=0: count holds.
- IDLE: count holds. en is ignored and no wrap to all-ones ever occurs.
- tc is high for exactly the one cycle following the 1→0 decrement edge. It clears on the next edge regardless of en.
- Next-state arithmetic is a WIDTH-bit borrow-chain decrementer:
  - bit i toggles when all lower bits are 0;
  - d0 = ~c0.
  - No extra bits are carried.

## Timing
- Load latency: count shows load_val one cycle after the load edge.
- Decrement latency: one enabled edge per step.
- tc and count=0 are asserted in the same cycle.
- running equals state==RUN and is registered.
- One-shot mode: from load of N with en held high, tc is seen on the Nth enabled edge after the load. After that, running=0.
- Auto-reload mode with en held high: tc period is N+1 cycles, covering the countdown N..0 and then the reload.
- A load on the same edge as 1→0 loads, and tc stays 0.
- Reset asserted mid-count clears on that edge. No tc is generated.

## Structure
- Shared package `counter_pkg`:
  - WIDTH default;
  - state encoding constants ST_IDLE=1'b0, ST_RUN=1'b1.
- Sub-module `dff_sr`: 1-bit D flip-flop with synchronous active-high reset, instantiated per state bit.
- The decrementer and next-state mux are gate primitives in the top module. No behavioral arithmetic.

## Test plan
- Reset then idle: rst=1 for 2 cycles, then en=1 for 5 cycles → count=0, tc=0, running=0 throughout; no wrap to 7.
- One-shot from 5 (WIDTH=3, auto=0): count sequence 5,4,3,2,1,0. tc=1 only in the cycle where count=0. running drops with that cycle, and count stays 0 for 3 further enabled cycles.
- Auto-reload from 3 (auto=1, en=1): count sequence 3,2,1,0,3,2,1,0. tc pulses every 4 cycles and running stays 1.
- Enable gaps: load 4, then en pattern 1,0,0,1,1,1 → count 3,3,3,2,1,0. tc is high only on the final cycle.
- Collisions:
  - load=1 with en=1 while count=1 and load_val=6 → count=6, tc=0.
  - rst=1 while count=2 → count=0, running=0, and no tc.
- Load of zero: load_val=0 with auto=1 → count=0, running=0, tc never asserted; max value 7 counts down correctly afterward.
